assoc_cache: RTL and testbench
==============================

ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 Parameter NUM_SETS, default 16, number of sets; power of 2, at least 2.
REQ-002 Parameter NUM_WAYS, default 2, ways per set; power of 2, at least 1.
REQ-003 Parameter BLOCK_WORDS, default 4, 32-bit words per line; power of 2, at least 2.
REQ-004 Port clk, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit, synchronous active-high reset.
REQ-006 Port cpu_req, input, 1 bit, CPU access request.
REQ-007 Port cpu_we, input, 1 bit, 1 = write, 0 = read.
REQ-008 Port cpu_addr, input, 30 bits [31:2], word address.
REQ-009 Port cpu_wdata, input, 32 bits, write data.
REQ-010 Port cpu_rdata, output, 32 bits, read data; valid when cpu_ready=1 and cpu_req=1 and cpu_we=0.
REQ-011 Port cpu_ready, output, 1 bit, access completes this cycle; 0 = stall.
REQ-012 Port mem_req, output, 1 bit, backing-memory beat request.
REQ-013 Port mem_we, output, 1 bit, beat is a write-back.
REQ-014 Port mem_addr, output, 30 bits, beat word address.
REQ-015 Port mem_wdata, output, 32 bits, write-back word.
REQ-016 Port mem_ack, input, 1 bit, beat accepted; for reads, mem_rdata is valid in the same cycle.
REQ-017 Port mem_rdata, input, 32 bits, refill word.

Function
REQ-018 Address split: offset = low log2(BLOCK_WORDS) bits; index = next log2(NUM_SETS) bits; tag = remaining upper bits.
REQ-019 Per line: valid bit, dirty bit, tag, and BLOCK_WORDS data words.
REQ-020 Lookup is combinational. A hit in IDLE with cpu_req=1 drives cpu_ready=1 in the same cycle; cpu_rdata is the addressed word of the hitting way.
REQ-021 Write hit: updates the word at the clock edge, sets dirty, with zero stall.
REQ-022 Replacement: victim is the lowest-index invalid way; if all ways are valid, victim is victim_ptr[set].
REQ-023 victim_ptr[set] increments modulo NUM_WAYS after every refill that used it; hits do not change it.
REQ-024 FSM states are IDLE, WRITEBACK and REFILL.
REQ-025 IDLE -> WRITEBACK on a miss with a valid, dirty victim; IDLE -> REFILL on a miss otherwise.
REQ-026 WRITEBACK issues BLOCK_WORDS write beats, offsets 0..BLOCK_WORDS-1, at the victim's old tag and index; it goes to REFILL after the last mem_ack.
REQ-027 REFILL issues BLOCK_WORDS read beats, offsets 0..BLOCK_WORDS-1, capturing mem_rdata on each mem_ack. After the last ack it sets tag, valid=1, dirty=0, and returns to IDLE.
REQ-028 In IDLE the request replays as a hit; miss latency = beats + 1 cycle. Write-allocate: the replayed write then sets dirty.
REQ-029 mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack. The beat counter advances only on mem_ack; mem_req may stay high between beats.
REQ-030 cpu_ready=0 while not in IDLE, and on a miss in IDLE.
REQ-031 The CPU holds cpu_req, cpu_we, cpu_addr and cpu_wdata stable while cpu_ready=0.
REQ-032 cpu_req=0 in IDLE: cpu_ready=1, no state change, mem_req=0.
REQ-033 mem_ack outside WRITEBACK/REFILL is ignored.

Reset
REQ-034 rst clears all valid and dirty bits, all victim_ptr entries, and the beat counter, and sets the FSM to IDLE; data and tag arrays are not reset.
REQ-035 During rst and the cycle after: mem_req=0, mem_we=0, cpu_ready=0 while rst=1.
REQ-036 rst mid-WRITEBACK or mid-REFILL abandons the transfer; no line becomes valid.

Structure
REQ-037 Package cache_pkg holds the state enum (IDLE, WRITEBACK, REFILL), the default parameter values, and the address-field width functions.
REQ-038 Sub-module cache_way_lookup (tag compare across ways, returning hit, hit_way and first_invalid_way) is instantiated once.

Verification (defaults unless stated; memory acks every beat)
REQ-039 Cold read of 0x10: 4 read beats at 0x10..0x13 return 0xA0..0xA3; cpu_ready=1 one cycle after the last ack with cpu_rdata=0xA0. A following read of 0x12 hits with zero stall, returns 0xA2, and mem_req stays 0.
REQ-040 Write 0xDEADBEEF to 0x11 (hit, dirty), then read 0x51 and 0x91 (set 4, tags 1 and 2). The 0x91 miss writes back 4 beats to 0x10..0x13 with word 1 = 0xDEADBEEF, then refills.
REQ-041 Write miss of 0x12345678 to 0x20: refill 0x20..0x23, then a read of 0x20 returns 0x12345678 and the line is dirty.
REQ-042 rst asserted after the 2nd refill ack: mem_req=0 next cycle, and a re-read of the same address performs a full 4-beat refill.
REQ-043 NUM_WAYS=1, NUM_SETS=4, BLOCK_WORDS=8: alternating reads of 0x00 and 0x20 miss every time, with 8 beats each.
REQ-044 Stall the memory with mem_ack=0 for 5 cycles per beat: mem outputs are stable, the beat count is correct, and cpu_ready stays 0 throughout.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the set-associative write-back cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } cache_state_t;

    localparam int DEF_NUM_SETS    = 16;
    localparam int DEF_NUM_WAYS    = 2;
    localparam int DEF_BLOCK_WORDS = 4;
    localparam int ADDR_W          = 30;

    function automatic int offset_bits(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int index_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_bits(input int num_sets, input int block_words);
        return ADDR_W - $clog2(num_sets) - $clog2(block_words);
    endfunction

    // A single-way cache still needs a 1-bit way select.
    function automatic int way_bits(input int num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

endpackage

// File: rtl/cache_way_lookup.sv
// Parallel tag compare across the ways of one set; also locates the lowest invalid way.
module cache_way_lookup
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    parameter int TAG_W    = 24,
    parameter int WAY_W    = way_bits(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0]       way_valid,
    input  logic [NUM_WAYS*TAG_W-1:0] way_tags,
    input  logic [TAG_W-1:0]          lookup_tag,
    output logic                      hit,
    output logic [WAY_W-1:0]          hit_way,
    output logic                      has_invalid,
    output logic [WAY_W-1:0]          first_invalid_way
);

    // Scan high to low so the lowest matching / invalid way wins.
    always_comb begin
        hit               = 1'b0;
        hit_way           = '0;
        has_invalid       = 1'b0;
        first_invalid_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (way_valid[w] && (way_tags[w*TAG_W +: TAG_W] == lookup_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!way_valid[w]) begin
                has_invalid       = 1'b1;
                first_invalid_way = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// Blocking set-associative write-back / write-allocate cache with a one-beat-at-a-time
// memory port.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | lookup; hits complete in-cycle, a miss picks a victim
// WRITEBACK | streaming the dirty victim line out, offsets 0..N-1
// REFILL    | streaming the missing line in, then replay in IDLE
module assoc_cache
    import cache_pkg::*;
#(
    parameter int NUM_SETS    = DEF_NUM_SETS,
    parameter int NUM_WAYS    = DEF_NUM_WAYS,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:2] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:2] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int OFF_W = offset_bits(BLOCK_WORDS);
    localparam int IDX_W = index_bits(NUM_SETS);
    localparam int TAG_W = tag_bits(NUM_SETS, BLOCK_WORDS);
    localparam int WAY_W = way_bits(NUM_WAYS);

    logic [NUM_WAYS-1:0] valid_q      [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q      [NUM_SETS];
    logic [WAY_W-1:0]    victim_ptr_q [NUM_SETS];
    logic [TAG_W-1:0]    tag_q        [NUM_SETS][NUM_WAYS];
    logic [31:0]         data_q       [NUM_SETS][NUM_WAYS][BLOCK_WORDS];

    cache_state_t     state_q, state_d;
    logic [OFF_W-1:0] beat_q;
    logic [WAY_W-1:0] vway_q;
    logic             use_ptr_q;

    logic [OFF_W-1:0] cpu_off;
    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;

    assign cpu_off = cpu_addr[2 +: OFF_W];
    assign cpu_idx = cpu_addr[2 + OFF_W +: IDX_W];
    assign cpu_tag = cpu_addr[31 -: TAG_W];

    logic [NUM_WAYS*TAG_W-1:0] set_tags;
    logic                      hit;
    logic [WAY_W-1:0]          hit_way;
    logic                      has_invalid;
    logic [WAY_W-1:0]          first_invalid_way;
    logic [WAY_W-1:0]          victim_way;
    logic                      victim_dirty;
    logic                      last_ack;

    always_comb begin
        set_tags = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            set_tags[w*TAG_W +: TAG_W] = tag_q[cpu_idx][w];
        end
    end

    cache_way_lookup #(
        .NUM_WAYS (NUM_WAYS),
        .TAG_W    (TAG_W),
        .WAY_W    (WAY_W)
    ) u_lookup (
        .way_valid         (valid_q[cpu_idx]),
        .way_tags          (set_tags),
        .lookup_tag        (cpu_tag),
        .hit               (hit),
        .hit_way           (hit_way),
        .has_invalid       (has_invalid),
        .first_invalid_way (first_invalid_way)
    );

    assign victim_way   = has_invalid ? first_invalid_way : victim_ptr_q[cpu_idx];
    assign victim_dirty = valid_q[cpu_idx][victim_way] && dirty_q[cpu_idx][victim_way];
    assign last_ack     = mem_ack && (beat_q == OFF_W'(BLOCK_WORDS - 1));
    assign cpu_rdata    = data_q[cpu_idx][hit_way][cpu_off];

    always_comb begin
        state_d   = state_q;
        cpu_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                cpu_ready = !cpu_req || hit;
                if (cpu_req && !hit) begin
                    state_d = victim_dirty ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[cpu_idx][vway_q], cpu_idx, beat_q};
                mem_wdata = data_q[cpu_idx][vway_q][beat_q];
                if (last_ack) state_d = REFILL;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {cpu_tag, cpu_idx, beat_q};
                if (last_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Memory must see nothing while reset is held, even mid-transfer.
        if (rst) begin
            cpu_ready = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            vway_q    <= '0;
            use_ptr_q <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s]      <= '0;
                dirty_q[s]      <= '0;
                victim_ptr_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (cpu_req && hit && cpu_we) begin
                        dirty_q[cpu_idx][hit_way] <= 1'b1;
                    end else if (cpu_req && !hit) begin
                        vway_q    <= victim_way;
                        use_ptr_q <= !has_invalid;
                    end
                end
                WRITEBACK, REFILL: begin
                    if (mem_ack) beat_q <= beat_q + 1'b1;
                end
                default: ;
            endcase
            if (state_q == REFILL && last_ack) begin
                valid_q[cpu_idx][vway_q] <= 1'b1;
                dirty_q[cpu_idx][vway_q] <= 1'b0;
                if (use_ptr_q) begin
                    victim_ptr_q[cpu_idx] <= (victim_ptr_q[cpu_idx] == WAY_W'(NUM_WAYS - 1))
                                             ? '0 : victim_ptr_q[cpu_idx] + 1'b1;
                end
            end
        end
    end

    // Tag and data arrays carry no reset; validity alone decides what is live.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == IDLE && cpu_req && cpu_we && hit) begin
                data_q[cpu_idx][hit_way][cpu_off] <= cpu_wdata;
            end
            if (state_q == REFILL && mem_ack) begin
                data_q[cpu_idx][vway_q][beat_q] <= mem_rdata;
            end
            if (state_q == REFILL && last_ack) begin
                tag_q[cpu_idx][vway_q] <= cpu_tag;
            end
        end
    end

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache: default 2-way instance plus a direct-mapped instance,
// each backed by a simple word memory model.
module tb_assoc_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:2] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready, mem_req, mem_we, mem_ack;
    logic [31:2] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        cpu1_req = 1'b0, cpu1_we = 1'b0;
    logic [31:2] cpu1_addr = '0;
    logic [31:0] cpu1_wdata = '0;
    logic [31:0] cpu1_rdata;
    logic        cpu1_ready, mem1_req, mem1_we, mem1_ack;
    logic [31:2] mem1_addr;
    logic [31:0] mem1_wdata, mem1_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assoc_cache dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    assoc_cache #(.NUM_SETS(4), .NUM_WAYS(1), .BLOCK_WORDS(8)) dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu1_req), .cpu_we(cpu1_we), .cpu_addr(cpu1_addr), .cpu_wdata(cpu1_wdata),
        .cpu_rdata(cpu1_rdata), .cpu_ready(cpu1_ready),
        .mem_req(mem1_req), .mem_we(mem1_we), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata),
        .mem_ack(mem1_ack), .mem_rdata(mem1_rdata)
    );

    // Memory model for the main instance: word a initially holds a + 0x90.
    logic [31:0] mem_arr [256];
    logic        mem_init = 1'b1;
    int          stall_cycles = 0;
    int          stall_cnt = 0;
    int          rd_beats = 0, wr_beats = 0, unstable = 0, ready_in_xfer = 0;
    logic [29:0] rd_addr_q[$];
    logic [29:0] wb_addr_q[$];
    logic [31:0] wb_data_q[$];
    logic        prev_pending = 1'b0, prev_we = 1'b0;
    logic [29:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;

    assign mem_ack   = mem_req && (stall_cnt >= stall_cycles);
    assign mem_rdata = mem_arr[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= 32'(i) + 32'h90;
        end else if (mem_req && mem_ack) begin
            if (mem_we) begin
                mem_arr[mem_addr[9:2]] <= mem_wdata;
                wr_beats++;
                wb_addr_q.push_back(mem_addr);
                wb_data_q.push_back(mem_wdata);
            end else begin
                rd_beats++;
                rd_addr_q.push_back(mem_addr);
            end
        end
        stall_cnt <= (mem_req && !mem_ack) ? stall_cnt + 1 : 0;
        if (prev_pending && (mem_req !== 1'b1 || mem_we !== prev_we ||
                             mem_addr !== prev_addr || mem_wdata !== prev_wdata)) unstable++;
        if (mem_req && cpu_ready) ready_in_xfer++;
        prev_pending = mem_req && !mem_ack;
        prev_we      = mem_we;
        prev_addr    = mem_addr;
        prev_wdata   = mem_wdata;
    end

    // Direct-mapped instance: memory always acks, word a holds a + 0x90.
    int rd1_beats = 0;
    assign mem1_ack   = mem1_req;
    assign mem1_rdata = {2'b00, mem1_addr} + 32'h90;
    always @(posedge clk) if (mem1_req && mem1_ack && !mem1_we) rd1_beats++;

    task automatic cpu_access(input bit sel, input bit we, input logic [29:0] addr,
                              input logic [31:0] wd, output logic [31:0] rd, output int stall);
        if (sel) begin
            cpu1_req = 1'b1; cpu1_we = we; cpu1_addr = addr; cpu1_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end
        stall = 0;
        @(negedge clk);
        while (!(sel ? cpu1_ready : cpu_ready) && stall < 400) begin
            stall++;
            @(negedge clk);
        end
        rd = sel ? cpu1_rdata : cpu_rdata;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu1_req = 1'b0; cpu1_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_init = 1'b1;
        cpu_req = 1'b1; cpu_addr = 30'h10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_ready: got %b expected 0", cpu_ready); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
        @(posedge clk); #1;
        rst = 1'b0; mem_init = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL post_rst_mem_req: got %b expected 0", mem_req); end
        n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL idle_no_req_ready: got %b expected 1", cpu_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_cold_read();
        logic [31:0] rd;
        int st, r0;
        r0 = rd_beats; rd_addr_q.delete();
        cpu_access(0, 0, 30'h10, '0, rd, st);
        n_checks++; if (rd !== 32'hA0) begin n_fail++; $display("FAIL cold_rdata: got %h expected a0", rd); end
        n_checks++; if (st !== 5) begin n_fail++; $display("FAIL cold_latency: got %0d expected 5", st); end
        n_checks++; if (rd_beats - r0 !== 4) begin n_fail++; $display("FAIL cold_beats: got %0d expected 4", rd_beats - r0); end
        n_checks++;
        if (rd_addr_q.size() != 4) begin n_fail++; $display("FAIL cold_addr_count: got %0d expected 4", rd_addr_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            if (i > 0) n_checks++;
            if (rd_addr_q[i] !== 30'h10 + 30'(i)) begin n_fail++; $display("FAIL cold_addr%0d: got %h expected %h", i, rd_addr_q[i], 30'h10 + 30'(i)); end
        end
        r0 = rd_beats;
        cpu_access(0, 0, 30'h12, '0, rd, st);
        n_checks++; if (rd !== 32'hA2) begin n_fail++; $display("FAIL hit_rdata: got %h expected a2", rd); end
        n_checks++; if (st !== 0) begin n_fail++; $display("FAIL hit_latency: got %0d expected 0", st); end
        n_checks++; if (rd_beats !== r0) begin n_fail++; $display("FAIL hit_mem_beats: got %0d expected %0d", rd_beats, r0); end
    endtask

    task automatic test_write_hit_evict();
        logic [31:0] rd;
        int st, r0, w0;
        r0 = rd_beats; w0 = wr_beats;
        cpu_access(0, 1, 30'h11, 32'hDEADBEEF, rd, st);
        n_checks++; if (st !== 0) begin n_fail++; $display("FAIL wr_hit_latency: got %0d expected 0", st); end
        n_checks++; if (rd_beats + wr_beats !== r0 + w0) begin n_fail++; $display("FAIL wr_hit_beats: got %0d expected 0", rd_beats + wr_beats - r0 - w0); end
        cpu_access(0, 0, 30'h51, '0, rd, st);
        n_checks++; if (st !== 5 || rd !== 32'hE1) begin n_fail++; $display("FAIL fill_way1: got %0d/%h expected 5/e1", st, rd); end
        wb_addr_q.delete(); wb_data_q.delete(); w0 = wr_beats;
        cpu_access(0, 0, 30'h91, '0, rd, st);
        n_checks++; if (st !== 9) begin n_fail++; $display("FAIL evict_latency: got %0d expected 9", st); end
        n_checks++; if (rd !== 32'h121) begin n_fail++; $display("FAIL evict_rdata: got %h expected 121", rd); end
        n_checks++;
        if (wb_addr_q.size() != 4) begin n_fail++; $display("FAIL wb_count: got %0d expected 4", wb_addr_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                if (i > 0) n_checks++;
                if (wb_addr_q[i] !== 30'h10 + 30'(i)) begin n_fail++; $display("FAIL wb_addr%0d: got %h expected %h", i, wb_addr_q[i], 30'h10 + 30'(i)); end
            end
            n_checks++; if (wb_data_q[0] !== 32'hA0) begin n_fail++; $display("FAIL wb_word0: got %h expected a0", wb_data_q[0]); end
            n_checks++; if (wb_data_q[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wb_word1: got %h expected deadbeef", wb_data_q[1]); end
        end
        // victim pointer has moved to way 1 (tag 1, clean): refill only, memory holds the written-back word
        w0 = wr_beats;
        cpu_access(0, 0, 30'h11, '0, rd, st);
        n_checks++; if (st !== 5 || wr_beats !== w0) begin n_fail++; $display("FAIL ptr_victim: got %0d/%0d expected 5/0", st, wr_beats - w0); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL refetch_rdata: got %h expected deadbeef", rd); end
    endtask

    task automatic test_write_miss();
        logic [31:0] rd;
        int st, r0, w0;
        r0 = rd_beats; rd_addr_q.delete();
        cpu_access(0, 1, 30'h20, 32'h12345678, rd, st);
        n_checks++; if (st !== 5 || rd_beats - r0 !== 4) begin n_fail++; $display("FAIL wmiss_refill: got %0d/%0d expected 5/4", st, rd_beats - r0); end
        n_checks++; if (rd_addr_q.size() == 0 || rd_addr_q[0] !== 30'h20) begin n_fail++; $display("FAIL wmiss_addr: got %0d beats expected first 20", rd_addr_q.size()); end
        cpu_access(0, 0, 30'h20, '0, rd, st);
        n_checks++; if (rd !== 32'h12345678 || st !== 0) begin n_fail++; $display("FAIL wmiss_readback: got %h/%0d expected 12345678/0", rd, st); end
        cpu_access(0, 0, 30'h60, '0, rd, st);
        wb_addr_q.delete(); wb_data_q.delete(); w0 = wr_beats;
        cpu_access(0, 0, 30'hA0, '0, rd, st);
        n_checks++; if (st !== 9 || wr_beats - w0 !== 4) begin n_fail++; $display("FAIL wmiss_dirty_evict: got %0d/%0d expected 9/4", st, wr_beats - w0); end
        n_checks++; if (wb_data_q.size() == 0 || wb_data_q[0] !== 32'h12345678 || wb_addr_q[0] !== 30'h20) begin n_fail++; $display("FAIL wmiss_wb_word: got %0d beats expected 12345678 at 20", wb_data_q.size()); end
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] rd;
        int st, r0, cyc;
        r0 = rd_beats; cyc = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h30;
        @(negedge clk);
        while (rd_beats - r0 < 2 && cyc < 50) begin cyc++; @(negedge clk); end
        n_checks++; if (rd_beats - r0 !== 2) begin n_fail++; $display("FAIL midrst_reach: got %0d beats expected 2", rd_beats - r0); end
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got req %b ready %b expected 0 0", mem_req, cpu_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        r0 = rd_beats;
        cpu_access(0, 0, 30'h30, '0, rd, st);
        n_checks++; if (st !== 5 || rd_beats - r0 !== 4) begin n_fail++; $display("FAIL midrst_refetch: got %0d/%0d expected 5/4", st, rd_beats - r0); end
        n_checks++; if (rd !== 32'hC0) begin n_fail++; $display("FAIL midrst_rdata: got %h expected c0", rd); end
    endtask

    task automatic test_stall();
        logic [31:0] rd;
        int st, r0, w0, u0, x0;
        stall_cycles = 5;
        u0 = unstable; x0 = ready_in_xfer; r0 = rd_beats;
        cpu_access(0, 0, 30'h40, '0, rd, st);
        n_checks++; if (st !== 25 || rd_beats - r0 !== 4) begin n_fail++; $display("FAIL stall_refill: got %0d/%0d expected 25/4", st, rd_beats - r0); end
        n_checks++; if (rd !== 32'hD0) begin n_fail++; $display("FAIL stall_rdata: got %h expected d0", rd); end
        cpu_access(0, 1, 30'h41, 32'hCAFEF00D, rd, st);
        cpu_access(0, 0, 30'h80, '0, rd, st);
        wb_data_q.delete(); w0 = wr_beats;
        cpu_access(0, 0, 30'hC0, '0, rd, st);
        n_checks++; if (st !== 49 || wr_beats - w0 !== 4) begin n_fail++; $display("FAIL stall_wb: got %0d/%0d expected 49/4", st, wr_beats - w0); end
        n_checks++; if (wb_data_q.size() < 2 || wb_data_q[1] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL stall_wb_word: got %0d beats expected cafef00d", wb_data_q.size()); end
        n_checks++; if (unstable !== u0) begin n_fail++; $display("FAIL stall_stability: got %0d changes expected 0", unstable - u0); end
        n_checks++; if (ready_in_xfer !== x0) begin n_fail++; $display("FAIL stall_ready: got %0d cycles expected 0", ready_in_xfer - x0); end
        stall_cycles = 0;
    endtask

    task automatic test_direct_mapped();
        logic [31:0] rd;
        logic [29:0] a;
        int st, r0;
        for (int k = 0; k < 4; k++) begin
            a = (k % 2 == 0) ? 30'h00 : 30'h20;
            r0 = rd1_beats;
            cpu_access(1, 0, a, '0, rd, st);
            n_checks++; if (st !== 9) begin n_fail++; $display("FAIL dm_latency%0d: got %0d expected 9", k, st); end
            n_checks++; if (rd1_beats - r0 !== 8) begin n_fail++; $display("FAIL dm_beats%0d: got %0d expected 8", k, rd1_beats - r0); end
            n_checks++; if (rd !== {2'b00, a} + 32'h90) begin n_fail++; $display("FAIL dm_rdata%0d: got %h expected %h", k, rd, {2'b00, a} + 32'h90); end
        end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_write_hit_evict();
        test_write_miss();
        test_reset_mid_refill();
        test_stall();
        test_direct_mapped();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
